// File: rtl/img_jpeg_dequantizer.sv
// JPEG coefficient dequantizer: accepts one 8x8 block of quantized
// coefficients in zigzag order, multiplies each by the fixed Annex K
// luminance table entry, and replays the block in raster order.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FILL  | accepting zigzag beats into the buffer, in_ready high
// S_DRAIN | presenting buffered results in raster order, out_valid high

module img_jpeg_dequantizer #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [5:0]               out_idx,
    output logic                     out_last,
    output logic                     err
);

    // Product of a DATA_W signed value and a 9-bit non-negative table value.
    localparam int PROD_W = DATA_W + 9;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    // Zigzag position k -> raster index row*8+col.
    localparam logic [5:0] ZZ_ROM [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Luminance quantization table, raster order.
    localparam logic [7:0] Q_ROM [64] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    state_t state_q, state_d;
    logic [5:0] k_q, k_d;
    logic [5:0] r_q, r_d;
    logic       err_q;
    logic       in_fire;

    logic signed [DATA_W-1:0] buf_mem [64];

    logic [5:0]               wr_addr;
    logic [7:0]               q_val;
    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] q_ext;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_fits;
    logic signed [DATA_W-1:0] sat_val;

    assign wr_addr  = ZZ_ROM[k_q];
    assign q_val    = Q_ROM[wr_addr];
    assign data_ext = PROD_W'(in_data);
    assign q_ext    = PROD_W'({1'b0, q_val});
    assign prod     = data_ext * q_ext;

    // Product fits DATA_W when every bit above the result sign bit matches it.
    assign prod_fits = (prod[PROD_W-1:DATA_W-1] == {(PROD_W-DATA_W+1){prod[PROD_W-1]}});
    assign sat_val   = prod_fits     ? prod[DATA_W-1:0] :
                       prod[PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                        {1'b0, {(DATA_W-1){1'b1}}};

    assign in_fire  = in_valid & in_ready;
    assign out_data = buf_mem[r_q];
    assign out_idx  = r_q;
    assign out_last = (r_q == 6'd63);
    assign err      = err_q;

    // State, counters and sticky framing error; framing follows k alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            k_q     <= 6'd0;
            r_q     <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
            err_q   <= err_q | (in_fire & (in_last != (k_q == 6'd63)));
        end
    end

    // Next state, counter advance and handshake outputs.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        r_d       = r_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    k_d = k_q + 6'd1;
                    if (k_q == 6'd63) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    r_d = r_q + 6'd1;
                    if (r_q == 6'd63) begin
                        state_d = S_FILL;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Buffer write of the saturated product; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && in_fire) begin
            buf_mem[wr_addr] <= sat_val;
        end
    end

endmodule

// File: tb/tb_img_jpeg_dequantizer.sv
// Scoreboard bench for img_jpeg_dequantizer: stimulus pushes expected raster
// output per block; a negedge monitor pops and compares each output beat.

module tb_img_jpeg_dequantizer;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [5:0]         out_idx;
    logic               out_last;
    logic               err;

    img_jpeg_dequantizer #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    localparam int ZZ_T [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    localparam int Q_T [64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };

    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    int   gap_max = 0;
    int   vec [64];
    bit   lastv [64];
    int   expv [64];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat_mul(input int d, input int q);
        longint p;
        p = longint'(d) * longint'(q);
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return int'(p);
    endfunction

    function automatic void default_last();
        for (int i = 0; i < 64; i++) lastv[i] = (i == 63);
    endfunction

    function automatic void model_block();
        for (int k = 0; k < 64; k++) expv[ZZ_T[k]] = sat_mul(vec[k], Q_T[ZZ_T[k]]);
    endfunction

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input int d, input bit l);
        int budget;
        budget = 0;
        in_valid = 1'b1;
        in_data  = 16'(d);
        in_last  = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 5000) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input int err_k);
        for (int k = 0; k < 64; k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            send_beat(vec[k], lastv[k]);
            if (k >= err_k) check("err_sticky", err, 1);
        end
        for (int i = 0; i < 64; i++) exp_q.push_back('{expv[i], i, (i == 63)});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("back_to_fill_out_valid", out_valid, 0);
        check("back_to_fill_in_ready", in_ready, 1);
    endtask

    // out_ready: held high, or randomly dropped to create consumer stalls.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compare each output beat against the scoreboard, check hold under stall.
    initial begin
        bit                 prev_stall;
        logic signed [15:0] prev_data;
        logic [5:0]         prev_idx;
        logic               prev_last;
        exp_t               e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (out_valid) check("in_ready_low_in_drain", in_ready, 0);
                if (prev_stall && out_valid) begin
                    check("stall_hold_data", out_data, prev_data);
                    check("stall_hold_idx", out_idx, prev_idx);
                    check("stall_hold_last", out_last, prev_last);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_idx   = out_idx;
                prev_last  = out_last;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: idx %0d data %0d with empty scoreboard", out_idx, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_idx", out_idx, e.idx);
                        check("out_last", out_last, e.last);
                    end
                end
            end
        end
    end

    initial begin
        int           n;
        logic [15:0]  r16;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);

        // All +1: outputs are the table itself in raster order.
        default_last();
        for (int k = 0; k < 64; k++) vec[k] = 1;
        for (int i = 0; i < 64; i++) expv[i] = Q_T[i];
        send_block(64);
        wait_drain();
        check("ones_err", err, 0);

        // Saturation corners, hand-computed.
        for (int k = 0; k < 64; k++) vec[k] = 0;
        vec[0] = 32767;
        vec[1] = -3;
        vec[2] = -32768;
        for (int i = 0; i < 64; i++) expv[i] = 0;
        expv[0] = 32767;
        expv[1] = -33;
        expv[8] = -32768;
        send_block(64);
        wait_drain();

        // Three back-to-back random blocks with input gaps and output stalls.
        rand_ready = 1'b1;
        gap_max    = 3;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 64; k++) begin
                case ($urandom_range(0, 3))
                    0: begin r16 = 16'($urandom); vec[k] = int'($signed(r16)); end
                    1: vec[k] = int'($urandom_range(0, 100)) - 50;
                    2: vec[k] = 0;
                    default: vec[k] = int'($urandom_range(0, 6000)) - 3000;
                endcase
            end
            model_block();
            send_block(64);
        end
        wait_drain();
        check("random_err", err, 0);
        rand_ready = 1'b0;
        gap_max    = 0;

        // Early in_last on beat 10: err sticks, block still completes on k.
        for (int k = 0; k < 64; k++) vec[k] = k - 20;
        lastv[9] = 1'b1;
        model_block();
        send_block(9);
        wait_drain();
        check("framing_err_final", err, 1);
        default_last();

        // Reset in the middle of DRAIN at r=20.
        for (int k = 0; k < 64; k++) vec[k] = 3 * k - 90;
        model_block();
        send_block(64);
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_idx == 6'd20) break;
            n++;
            if (n > 500) begin
                check("reach_r20_timeout", 0, 1);
                break;
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_idx", out_idx, 0);
        check("midrst_err", err, 0);

        for (int k = 0; k < 64; k++) vec[k] = 100 - 7 * k;
        model_block();
        send_block(64);
        wait_drain();
        check("final_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
